// File: rtl/seqmult_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier.
// FSM states, Booth step decode and the per-cycle control bundle.
package seqmult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        NOP,
        ADD,
        SUB
    } booth_e;

    typedef struct packed {
        logic load;
        logic iterate;
        logic latch_product;
    } ctrl_t;

    function automatic booth_e booth_decode(input logic q0, input logic q1);
        booth_e op;
        op = NOP;
        unique case ({q0, q1})
            2'b01:   op = ADD;
            2'b10:   op = SUB;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_seq_datapath.sv
// M/ACC/Q/Q_1 registers with the Booth add/sub and arithmetic shift.
// o_prod_nxt is the product as it will read after the current iteration.
module booth_seq_datapath
    import seqmult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_load,
    input  logic           i_iter,
    input  logic           i_ext_a,
    input  logic           i_ext_b,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic [2*W-1:0] o_prod_nxt
);

    logic [W:0]   r_m;
    logic [W:0]   r_q;
    logic [W+1:0] r_acc;
    logic         r_q1;

    logic [W+1:0] w_m_ext;
    logic [W+1:0] w_sum;
    logic [W+1:0] w_acc_nxt;
    logic [W:0]   w_q_nxt;
    logic         w_q1_nxt;
    booth_e       w_op;

    always_comb begin
        w_m_ext = {r_m[W], r_m};
        w_op    = booth_decode(r_q[0], r_q1);
        w_sum   = r_acc;
        unique case (w_op)
            ADD:     w_sum = r_acc + w_m_ext;
            SUB:     w_sum = r_acc - w_m_ext;
            default: w_sum = r_acc;
        endcase
        // {ACC,Q,Q_1} >>> 1 applied to the post-add accumulator
        w_acc_nxt  = {w_sum[W+1], w_sum[W+1:1]};
        w_q_nxt    = {w_sum[0], r_q[W:1]};
        w_q1_nxt   = r_q[0];
        o_prod_nxt = {w_acc_nxt[W-2:0], w_q_nxt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m   <= '0;
            r_q   <= '0;
            r_acc <= '0;
            r_q1  <= 1'b0;
        end else if (i_load) begin
            r_m   <= {i_ext_a, i_a};
            r_q   <= {i_ext_b, i_b};
            r_acc <= '0;
            r_q1  <= 1'b0;
        end else if (i_iter) begin
            r_acc <= w_acc_nxt;
            r_q   <= w_q_nxt;
            r_q1  <= w_q1_nxt;
        end
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, W+1 iterations, valid/ready on both sides.
// Define SEQMULT_UNSIGNED_EN to add the op_signed port for unsigned operands.
module booth_mult_seq
    import seqmult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
`ifdef SEQMULT_UNSIGNED_EN
    input  logic           op_signed,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    localparam int CW = $clog2(W + 2);

    state_e         r_state;
    state_e         w_state_nxt;
    ctrl_t          w_ctrl;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_product;
    logic [2*W-1:0] w_prod_nxt;
    logic           w_ext_a;
    logic           w_ext_b;

`ifdef SEQMULT_UNSIGNED_EN
    assign w_ext_a = op_signed & a[W-1];
    assign w_ext_b = op_signed & b[W-1];
`else
    assign w_ext_a = a[W-1];
    assign w_ext_b = b[W-1];
`endif

    booth_seq_datapath #(.W(W)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_ctrl.load),
        .i_iter     (w_ctrl.iterate),
        .i_ext_a    (w_ext_a),
        .i_ext_b    (w_ext_b),
        .i_a        (a),
        .i_b        (b),
        .o_prod_nxt (w_prod_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl      = '0;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_ctrl.load = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                w_ctrl.iterate = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_ctrl.latch_product = 1'b1;
                    w_state_nxt          = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_ctrl.load) begin
            r_cnt <= CW'(W + 1);
        end else if (w_ctrl.iterate) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_product <= '0;
        end else if (w_ctrl.latch_product) begin
            r_product <= w_prod_nxt;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign product   = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: W=8 instance checked every cycle against a
// timestamp model, plus a W=16 instance for wide and random signed products.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv8, ir8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        iv16, ir16, ov16, or16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    logic        sgn8;
`ifdef SEQMULT_UNSIGNED_EN
    logic        s8;
    logic        s16;
    assign sgn8 = s8;
`else
    assign sgn8 = 1'b1;
`endif

    booth_mult_seq #(.W(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .a         (a8),
        .b         (b8),
`ifdef SEQMULT_UNSIGNED_EN
        .op_signed (s8),
`endif
        .out_valid (ov8),
        .out_ready (or8),
        .product   (p8),
        .busy      (busy8)
    );

    booth_mult_seq #(.W(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (a16),
        .b         (b16),
`ifdef SEQMULT_UNSIGNED_EN
        .op_signed (s16),
`endif
        .out_valid (ov16),
        .out_ready (or16),
        .product   (p16),
        .busy      (busy16)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic s);
        int vx;
        int vy;
        vx = s ? int'($signed(x)) : int'(x);
        vy = s ? int'($signed(y)) : int'(y);
        return 16'(vx * vy);
    endfunction

    function automatic logic [31:0] ref16(input logic [15:0] x,
                                          input logic [15:0] y);
        longint vx;
        longint vy;
        vx = longint'($signed(x));
        vy = longint'($signed(y));
        return 32'(vx * vy);
    endfunction

    // Timestamp model of the W=8 instance: an accepted pair becomes
    // visible W+1 edges later and stays until the output handshake.
    int          cyc = 0;
    bit          started = 1'b0;
    bit          pend = 1'b0;
    bit          ov_b;
    int          due = 0;
    logic [15:0] m_res = '0;
    logic [15:0] m_nxt = '0;

    always @(posedge clk) begin
        cyc++;
        started = 1'b1;
        ov_b = pend && (cyc - 1 >= due);
        if (rst) begin
            pend  = 1'b0;
            m_res = '0;
        end else begin
            if (!pend && iv8) begin
                pend  = 1'b1;
                due   = cyc + 9;
                m_nxt = ref8(a8, b8, sgn8);
            end else if (ov_b && or8) begin
                pend = 1'b0;
            end
            if (pend && cyc == due) m_res = m_nxt;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_in_ready", 32'(ir8), 32'(!pend));
            chk("m_out_valid", 32'(ov8), 32'(pend && cyc >= due));
            chk("m_busy", 32'(busy8), 32'(pend));
            chk("m_product", 32'(p8), 32'(m_res));
        end
    end

    task automatic op8(input logic [7:0] x, input logic [7:0] y,
                       input logic s, input logic [15:0] exp,
                       input int hold);
        int lat;
        chk("ref8_pin", 32'(ref8(x, y, s)), 32'(exp));
        @(negedge clk);
        a8  = x;
        b8  = y;
`ifdef SEQMULT_UNSIGNED_EN
        s8  = s;
`endif
        iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        a8  = ~x;
        b8  = ~y;
`ifdef SEQMULT_UNSIGNED_EN
        s8  = ~s;
`endif
        lat = 0;
        while (!ov8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency8", 32'(lat), 32'd9);
        chk("prod8", 32'(p8), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            iv8 = 1'b1;
            a8  = 8'h11 + 8'(i);
            @(negedge clk);
            chk("hold_prod8", 32'(p8), 32'(exp));
            chk("hold_ready8", 32'(ir8), 32'd0);
            chk("hold_valid8", 32'(ov8), 32'd1);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        or8 = 1'b0;
        chk("ready_after8", 32'(ir8), 32'd1);
        chk("valid_after8", 32'(ov8), 32'd0);
        chk("prod_kept8", 32'(p8), 32'(exp));
    endtask

    task automatic op16(input logic [15:0] x, input logic [15:0] y,
                        input logic [31:0] exp);
        int lat;
        @(negedge clk);
        a16  = x;
        b16  = y;
        iv16 = 1'b1;
        @(negedge clk);
        iv16 = 1'b0;
        lat  = 0;
        while (!ov16 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency16", 32'(lat), 32'd17);
        chk("prod16", p16, exp);
        or16 = 1'b1;
        @(negedge clk);
        or16 = 1'b0;
        chk("ready_after16", 32'(ir16), 32'd1);
    endtask

    initial begin
        logic [15:0] rx;
        logic [15:0] ry;
        rst  = 1'b1;
        iv8  = 1'b0;
        or8  = 1'b0;
        a8   = '0;
        b8   = '0;
        iv16 = 1'b0;
        or16 = 1'b0;
        a16  = '0;
        b16  = '0;
`ifdef SEQMULT_UNSIGNED_EN
        s8   = 1'b1;
        s16  = 1'b1;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready8", 32'(ir8), 32'd1);
        chk("rst_valid8", 32'(ov8), 32'd0);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_prod8", 32'(p8), 32'd0);
        chk("rst_prod16", p16, 32'd0);

        op8(8'd3,   8'd5,   1'b1, 16'h000F, 0);
        op8(8'h80,  8'h80,  1'b1, 16'h4000, 0);
        op8(8'hFF,  8'h7F,  1'b1, 16'hFF81, 0);
        op8(8'h00,  8'hB3,  1'b1, 16'h0000, 0);
`ifdef SEQMULT_UNSIGNED_EN
        op8(8'hFF,  8'hFF,  1'b0, 16'hFE01, 0);
        op8(8'hFF,  8'hFF,  1'b1, 16'h0001, 0);
`endif
        op8(8'h19,  8'hFD,  1'b1, 16'hFFB5, 5);

        @(negedge clk);
        a8  = 8'd100;
        b8  = 8'd100;
        iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready8", 32'(ir8), 32'd1);
        chk("abort_valid8", 32'(ov8), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_quiet8", 32'(ov8), 32'd0);
        end
        op8(8'd7, 8'd6, 1'b1, 16'h002A, 0);

        chk("ref16_pin", ref16(16'h8000, 16'h7FFF), 32'hC0008000);
        op16(16'h8000, 16'h7FFF, 32'hC0008000);
        op16(16'h8000, 16'h8000, 32'h40000000);
        for (int i = 0; i < 6; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            op16(rx, ry, ref16(rx, ry));
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
